// File: rtl/imm_field_encoder.sv
// imm_field_encoder: two-stage pipelined LEGv8 immediate encoder.
// Decodes the format from base_inst[31:21] and range-checks imm64 against that field.
// Inserts the immediate into the instruction word; this is the inverse of the sign-extender path.
//
// Optional build macro: IMM_ENC_SCALE_EN. When defined, CB/B immediates are byte
// offsets: they must be 4-byte aligned and are encoded as imm64 >>> 2.
//
// Ports:
//   Clk, resetl           clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   base_inst, imm64      instruction template and immediate value
//   out_valid / out_ready result handshake
//   inst_out, fmt_out     encoded word, format code (0 D, 1 CB, 2 B, 3 I, 4 shift, 7 unknown)
//   range_err             immediate not representable or opcode unknown
//   err_count             saturating count of emitted results with range_err set
module imm_field_encoder #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 Clk,
    input  logic                 resetl,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          base_inst,
    input  logic [63:0]          imm64,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inst_out,
    output logic [2:0]           fmt_out,
    output logic                 range_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_D   = 3'd0;
    localparam logic [2:0] FMT_CB  = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_I   = 3'd3;
    localparam logic [2:0] FMT_SH  = 3'd4;
    localparam logic [2:0] FMT_UNK = 3'd7;

    // Signed N-bit fit: bits [63:N-1] must all match the sign.
    function automatic logic sfits(input logic [63:0] v, input int unsigned n);
        logic [63:0] hi;
        hi = 64'($signed(v) >>> (n - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    // Unsigned N-bit fit: bits [63:N] must be zero.
    function automatic logic ufits(input logic [63:0] v, input int unsigned n);
        return (v >> n) == '0;
    endfunction

    logic [10:0] op;
    logic [63:0] br_val;
    logic        br_align;
    logic [63:0] val;
    logic [31:0] mask;
    logic [4:0]  lsb;
    logic        fits;
    logic [2:0]  s1_fmt_d;
    logic [31:0] s1_inst_d;
    logic        s1_err_d;

    logic                 s1_valid_q;
    logic [31:0]          s1_inst_q;
    logic [2:0]           s1_fmt_q;
    logic                 s1_err_q;
    logic                 out_valid_q;
    logic [31:0]          inst_out_q;
    logic [2:0]           fmt_out_q;
    logic                 range_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic s2_adv;
    logic s1_adv;

    assign op = base_inst[31:21];

    // Branch offsets: either used directly or converted from bytes to words.
`ifdef IMM_ENC_SCALE_EN
    assign br_val   = 64'($signed(imm64) >>> 2);
    assign br_align = (imm64[1:0] == 2'b00);
`else
    assign br_val   = imm64;
    assign br_align = 1'b1;
`endif

    // Format decode, range check and field insertion.
    always_comb begin
        s1_fmt_d = FMT_UNK;
        mask     = '0;
        lsb      = '0;
        fits     = 1'b0;
        val      = imm64;
        if ((op[10:2] == 9'b111110000) && !op[0]) begin
            s1_fmt_d = FMT_D;
            mask     = 32'h001F_F000;
            lsb      = 5'd12;
            fits     = sfits(imm64, 9);
        end else if (op[10:3] == 8'b10110100) begin
            s1_fmt_d = FMT_CB;
            mask     = 32'h00FF_FFE0;
            lsb      = 5'd5;
            val      = br_val;
            fits     = br_align && sfits(br_val, 19);
        end else if (op[10:5] == 6'b000101) begin
            s1_fmt_d = FMT_B;
            mask     = 32'h03FF_FFFF;
            lsb      = 5'd0;
            val      = br_val;
            fits     = br_align && sfits(br_val, 26);
        end else if (op[10:1] == 10'b1101001101) begin
            s1_fmt_d = FMT_SH;
            mask     = 32'h0000_FC00;
            lsb      = 5'd10;
            fits     = ufits(imm64, 6);
        end else if (op[10] && ((op[7:1] == 7'b1000100) || (op[7:1] == 7'b1001000))) begin
            s1_fmt_d = FMT_I;
            mask     = 32'h003F_FC00;
            lsb      = 5'd10;
            fits     = ufits(imm64, 12);
        end

        if (s1_fmt_d == FMT_UNK) begin
            s1_inst_d = base_inst;
            s1_err_d  = 1'b1;
        end else begin
            s1_inst_d = (base_inst & ~mask) | (fits ? ((val[31:0] << lsb) & mask) : 32'h0);
            s1_err_d  = !fits;
        end
    end

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: decoded and packed request.
    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            s1_fmt_q   <= '0;
            s1_err_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_inst_q <= s1_inst_d;
                s1_fmt_q  <= s1_fmt_d;
                s1_err_q  <= s1_err_d;
            end
        end
    end

    // Stage 2: registered outputs; held while the consumer stalls.
    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            out_valid_q <= 1'b0;
            inst_out_q  <= '0;
            fmt_out_q   <= '0;
            range_err_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                inst_out_q  <= s1_inst_q;
                fmt_out_q   <= s1_fmt_q;
                range_err_q <= s1_err_q;
            end
        end
    end

    // Saturating count of erroneous results taken by the consumer.
    always_ff @(posedge Clk or negedge resetl) begin
        if (!resetl) begin
            err_cnt_q <= '0;
        end else if (out_valid_q && out_ready && range_err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign inst_out  = inst_out_q;
    assign fmt_out   = fmt_out_q;
    assign range_err = range_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed self-checking bench for imm_field_encoder (error counter narrowed to 2 bits).
module tb_imm_field_encoder;

    localparam int unsigned CW = 2;

    logic          Clk = 1'b0;
    logic          resetl;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   base_inst;
    logic [63:0]   imm64;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   inst_out;
    logic [2:0]    fmt_out;
    logic          range_err;
    logic [CW-1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    imm_field_encoder #(.ERR_CNT_W(CW)) dut (
        .Clk       (Clk),
        .resetl    (resetl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base_inst (base_inst),
        .imm64     (imm64),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .fmt_out   (fmt_out),
        .range_err (range_err),
        .err_count (err_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bump_cnt();
        if (exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
    endtask

    // One request through an idle pipeline with out_ready held high.
    task automatic run_one(input string tag, input logic [31:0] b, input logic [63:0] imm,
                           input logic [31:0] ei, input logic [2:0] ef, input logic ee);
        @(negedge Clk);
        base_inst = b;
        imm64     = imm;
        in_valid  = 1'b1;
        #1 chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
        @(posedge Clk);
        #1 in_valid = 1'b0;
        @(negedge Clk);
        chk({tag, ".lat1"}, 64'(out_valid), 64'(0));
        chk({tag, ".cnt"}, 64'(err_count), 64'(exp_cnt));
        @(negedge Clk);
        chk({tag, ".vld"}, 64'(out_valid), 64'(1));
        chk({tag, ".inst"}, 64'(inst_out), 64'(ei));
        chk({tag, ".fmt"}, 64'(fmt_out), 64'(ef));
        chk({tag, ".err"}, 64'(range_err), 64'(ee));
        if (ee) bump_cnt();
    endtask

    logic [31:0] bq_base [4] = '{32'hF840_0000, 32'hD360_0000, 32'h9100_0000, 32'h0000_0000};
    logic [63:0] bq_imm  [4] = '{64'hFFFF_FFFF_FFFF_FF00, 64'd64, 64'd1, 64'd5};
    logic [31:0] bq_inst [4] = '{32'hF850_0000, 32'hD360_0000, 32'h9100_0400, 32'h0000_0000};
    logic [2:0]  bq_fmt  [4] = '{3'd0, 3'd4, 3'd3, 3'd7};
    logic        bq_err  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int sent;
        int got;
        resetl    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base_inst = '0;
        imm64     = '0;
        #12;
        chk("rst.vld", 64'(out_valid), 64'(0));
        chk("rst.inst", 64'(inst_out), 64'(0));
        chk("rst.fmt", 64'(fmt_out), 64'(0));
        chk("rst.err", 64'(range_err), 64'(0));
        chk("rst.cnt", 64'(err_count), 64'(0));
        @(negedge Clk);
        resetl = 1'b1;

        run_one("d_min",   32'hF840_0000, 64'hFFFF_FFFF_FFFF_FF00, 32'hF850_0000, 3'd0, 1'b0);
        run_one("d_256",   32'hF840_0000, 64'd256,                 32'hF840_0000, 3'd0, 1'b1);
        run_one("d_max",   32'hF840_0000, 64'd255,                 32'hF84F_F000, 3'd0, 1'b0);
        run_one("d_pass",  32'hF85F_F3E1, 64'd1,                   32'hF840_13E1, 3'd0, 1'b0);
        run_one("d_m257",  32'hF840_0000, 64'hFFFF_FFFF_FFFF_FEFF, 32'hF840_0000, 3'd0, 1'b1);
        run_one("addi",    32'h9100_0000, 64'd4095,                32'h913F_FC00, 3'd3, 1'b0);
        run_one("addi_of", 32'h9100_0000, 64'd4096,                32'h9100_0000, 3'd3, 1'b1);
        run_one("lsl63",   32'hD360_0000, 64'd63,                  32'hD360_FC00, 3'd4, 1'b0);
        run_one("lsl64",   32'hD360_0000, 64'd64,                  32'hD360_0000, 3'd4, 1'b1);
        run_one("unk",     32'h0000_0000, 64'd5,                   32'h0000_0000, 3'd7, 1'b1);
`ifdef IMM_ENC_SCALE_EN
        run_one("b_8",     32'h1400_0000, 64'd8,                   32'h1400_0002, 3'd2, 1'b0);
        run_one("b_6",     32'h1400_0000, 64'd6,                   32'h1400_0000, 3'd2, 1'b1);
        run_one("cbz",     32'hB400_0000, 64'd5460,                32'hB400_AAA0, 3'd1, 1'b0);
`else
        run_one("cbz",     32'hB400_0000, 64'd1365,                32'hB400_AAA0, 3'd1, 1'b0);
        run_one("cb_max",  32'hB400_0000, 64'd262143,              32'hB47F_FFE0, 3'd1, 1'b0);
        run_one("cb_of",   32'hB400_0000, 64'd262144,              32'hB400_0000, 3'd1, 1'b1);
        run_one("b_m1",    32'h1400_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h17FF_FFFF, 3'd2, 1'b0);
        run_one("b_6",     32'h1400_0000, 64'd6,                   32'h1400_0006, 3'd2, 1'b0);
`endif

        // Backpressure: consumer stalls for 5 cycles while 4 requests are offered.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge Clk);
            out_ready = (cyc >= 5);
            if (sent < 4) begin
                base_inst = bq_base[sent];
                imm64     = bq_imm[sent];
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("bp.hold_vld", 64'(out_valid), 64'(1));
                chk("bp.hold_inst", 64'(inst_out), 64'(bq_inst[0]));
            end
            if (cyc == 4) begin
                chk("bp.accepts", 64'(sent), 64'(2));
                chk("bp.rdy_low", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready) begin
                chk("bp.inst", 64'(inst_out), 64'(bq_inst[got]));
                chk("bp.fmt", 64'(fmt_out), 64'(bq_fmt[got]));
                chk("bp.err", 64'(range_err), 64'(bq_err[got]));
                if (bq_err[got]) bump_cnt();
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp.count", 64'(got), 64'(4));
        @(negedge Clk);
        chk("bp.drained", 64'(out_valid), 64'(0));
        chk("cnt.sat", 64'(err_count), 64'(exp_cnt));

        // Reset with both stages occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            base_inst = 32'hD360_0000;
            imm64     = 64'd100;
            in_valid  = 1'b1;
        end
        @(negedge Clk);
        in_valid = 1'b0;
        chk("mid.full", 64'(out_valid), 64'(1));
        #2 resetl = 1'b0;
        #1;
        chk("mid.vld", 64'(out_valid), 64'(0));
        chk("mid.cnt", 64'(err_count), 64'(0));
        chk("mid.inst", 64'(inst_out), 64'(0));
        chk("mid.err", 64'(range_err), 64'(0));
        @(negedge Clk);
        resetl    = 1'b1;
        out_ready = 1'b1;
        exp_cnt   = '0;
        run_one("post", 32'h9100_0000, 64'd7, 32'h9100_1C00, 3'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
